command_slave: RTL

Receiving end of the command bus driven by the command master: it samples the master's `addr`, `data_out`, `sw_out` and `reset_out` lines and applies each write strobe to a bank of 8-bit configuration registers. It exposes the register bank to the rest of the scan logic, and provides a registered read-back port, a write pulse, a start-command pulse and an acknowledge/error status. It sits between the command master and the acquisition/scan control logic.

---
 rtl/command_slave.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/command_slave.sv
// command_slave: receiving end of the command bus. Samples the master's
// address/data/strobe lines, applies each strobe as one write into a bank of
// 8-bit configuration registers, and reports write/start/ack/error status.
module command_slave #(
    parameter int NREG       = 16,
    parameter int ACK_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_in,
    input  logic [7:0]        addr,
    input  logic [7:0]        data_in,
    input  logic              sw_in,
    input  logic [7:0]        rd_addr,
    output logic [7:0]        rd_data,
    output logic [NREG*8-1:0] reg_flat,
    output logic              wr_pulse,
    output logic [7:0]        wr_index,
    output logic              start_pulse,
    output logic              ack,
    output logic              err
);

    localparam int         CW     = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES + 1) : 1;
    localparam logic [7:0] NREG_B = 8'(NREG);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        APPLY,
        ACK,
        WAIT_LOW
    } state_t;

    state_t          state;
    state_t          next_state;

    logic            rst;
    logic            sw_d;
    logic            sw_rise;
    logic [7:0]      cmd_addr;
    logic [7:0]      cmd_data;
    logic [CW-1:0]   ack_cnt;
    logic [7:0]      regs [NREG];
    logic [7:0]      rd_next;

    logic            capture_en;
    logic            apply_en;
    logic            ack_done;
    logic            in_range;
    logic            is_start;

    assign rst      = reset | reset_in;
    assign sw_rise  = sw_in & ~sw_d;
    assign in_range = (cmd_addr < NREG_B);
    assign is_start = (cmd_addr == 8'h01) && (cmd_data == 8'h01);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        next_state = state;
        capture_en = 1'b0;
        apply_en   = 1'b0;
        ack_done   = 1'b0;
        case (state)
            IDLE: begin
                if (sw_rise) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                capture_en = 1'b1;
                next_state = APPLY;
            end
            APPLY: begin
                apply_en   = 1'b1;
                next_state = ACK;
            end
            ACK: begin
                // Counter holds the number of ack cycles still owed, so the
                // last one is the cycle in which it reads 1.
                if (ack_cnt <= CW'(1)) begin
                    ack_done   = 1'b1;
                    next_state = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!sw_in) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Strobe edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_d <= 1'b0;
        end else begin
            sw_d <= sw_in;
        end
    end

    // Command latch, taken on the second strobe clock once the bus is stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_addr <= '0;
            cmd_data <= '0;
        end else if (capture_en) begin
            cmd_addr <= addr;
            cmd_data <= data_in;
        end
    end

    // Status outputs: write/start pulses, ack timing and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pulse    <= 1'b0;
            start_pulse <= 1'b0;
            wr_index    <= '0;
            ack         <= 1'b0;
            ack_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            wr_pulse    <= 1'b0;
            start_pulse <= 1'b0;
            if (apply_en) begin
                if (in_range) begin
                    wr_pulse <= 1'b1;
                    wr_index <= cmd_addr;
                end else begin
                    err <= 1'b1;
                end
                if (is_start) begin
                    start_pulse <= 1'b1;
                end
                ack     <= 1'b1;
                ack_cnt <= CW'(ACK_CYCLES);
            end else if (state == ACK) begin
                ack_cnt <= ack_cnt - CW'(1);
                if (ack_done) begin
                    ack <= 1'b0;
                end
            end
            if (sw_rise && (state != IDLE)) begin
                err <= 1'b1;
            end
        end
    end

    // Register bank write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (apply_en) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (cmd_addr == 8'(i)) begin
                    regs[i] <= cmd_data;
                end
            end
        end
    end

    // Read-back mux; out-of-range addresses match no entry and read as zero.
    always_comb begin
        rd_next = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (rd_addr == 8'(i)) begin
                rd_next = regs[i];
            end
        end
    end

    // Registered read-back port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

    // Flattened view of the register bank.
    always_comb begin
        reg_flat = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            reg_flat[8*i +: 8] = regs[i];
        end
    end

endmodule
